// File: rtl/gpio_apb_bridge.sv
// gpio_apb_bridge: APB3 slave in front of the GPIO register block.
// It turns bus transfers into single-cycle gpio_we/gpio_re strobes.
// It also provides a local SCRATCH register and a STATUS register
// holding the write and error counters.
// Optional build macro: GPIO_BRIDGE_SHADOW_EN. When it is defined,
// DATA reads are served from a local shadow of the last DATA write
// and the GPIO read strobe is never issued.
module gpio_apb_bridge #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [15:0] ERR_CNT_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              gpio_we,
  output logic              gpio_re,
  output logic [31:0]       gpio_wdata,
  input  logic [31:0]       gpio_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD, CAP, DONE} state_t;

  state_t      state;
  logic [31:0] scratch;
  logic [15:0] wr_cnt;
  logic [15:0] err_cnt;
  logic        err_flag;
`ifdef GPIO_BRIDGE_SHADOW_EN
  logic [31:0] shadow;
`endif

  logic access;
  logic hit_data;
  logic hit_status;
  logic hit_scratch;

  // Address decode. The full offset must match, so misaligned and out-of-map addresses fall through to the error path.
  assign access      = psel & penable;
  assign hit_data    = (paddr == ADDR_W'(0));
  assign hit_status  = (paddr == ADDR_W'(4));
  assign hit_scratch = (paddr == ADDR_W'(8));

  // Single transfer FSM. All bus and GPIO outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      prdata     <= 32'h0;
      gpio_wdata <= 32'h0;
      scratch    <= 32'h0;
      wr_cnt     <= 16'h0;
      err_cnt    <= 16'h0;
      err_flag   <= 1'b0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_re    <= 1'b0;
`ifdef GPIO_BRIDGE_SHADOW_EN
      shadow     <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (hit_data && pwrite) begin
              gpio_wdata <= pwdata;
              gpio_we    <= 1'b1;
`ifdef GPIO_BRIDGE_SHADOW_EN
              shadow     <= pwdata;
`endif
              state      <= WR;
            end else if (hit_data) begin
`ifdef GPIO_BRIDGE_SHADOW_EN
              prdata  <= shadow;
              pready  <= 1'b1;
              state   <= DONE;
`else
              gpio_re <= 1'b1;
              state   <= RD;
`endif
            end else if (hit_scratch) begin
              if (pwrite) begin
                scratch <= pwdata;
              end else begin
                prdata <= scratch;
              end
              pready <= 1'b1;
              state  <= DONE;
            end else if (hit_status && !pwrite) begin
              prdata <= {err_cnt, wr_cnt};
              pready <= 1'b1;
              state  <= DONE;
            end else begin
              prdata   <= 32'h0;
              err_flag <= 1'b1;
              pslverr  <= 1'b1;
              pready   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        WR: begin
          gpio_we <= 1'b0;
          wr_cnt  <= wr_cnt + 16'd1;
          pready  <= 1'b1;
          state   <= DONE;
        end
        RD: begin
          gpio_re <= 1'b0;
          state   <= CAP;
        end
        CAP: begin
          prdata <= gpio_rdata;
          pready <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          if (err_flag && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 16'd1;
          end
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          gpio_we <= 1'b0;
          gpio_re <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_apb_bridge.sv
// tb_gpio_apb_bridge: self-checking bench for gpio_apb_bridge.
// The bench holds a register-map level model: the counters, the scratch
// value, the last DATA write, and the expected latency of each access type.
// It drives directed scenarios followed by random APB traffic.
module tb_gpio_apb_bridge;

  localparam logic [15:0] ERR_MAX = 16'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [11:0] paddr = 12'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        gpio_we;
  logic        gpio_re;
  logic [31:0] gpio_wdata;
  logic [31:0] gpio_rdata = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model of the register map
  logic [15:0] m_wr      = 16'h0;
  logic [15:0] m_err     = 16'h0;
  logic [31:0] m_scratch = 32'h0;
  logic [31:0] m_last_wr = 32'h0;

  // value the bench GPIO returns one cycle after gpio_re
  logic [31:0] gpio_val = 32'h0;

  // per-transfer observations
  int          r_lat;
  logic [31:0] r_rdata;
  logic        r_err;
  int          r_we_n;
  int          r_re_n;
  int          r_both;
  logic [31:0] r_we_data;
  logic        r_pready_after;

  gpio_apb_bridge #(
    .ADDR_W(12),
    .ERR_CNT_MAX(ERR_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .gpio_we(gpio_we),
    .gpio_re(gpio_re),
    .gpio_wdata(gpio_wdata),
    .gpio_rdata(gpio_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One APB transfer: setup cycle, then access cycles until pready or a cycle budget expires.
  task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [31:0] wdata, input bit drop);
    int   n;
    logic prev_re;
    r_lat = 0; r_rdata = 32'h0; r_err = 1'b0;
    r_we_n = 0; r_re_n = 0; r_both = 0; r_we_data = 32'h0;
    prev_re = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 1;
    while (1) begin
      gpio_rdata = prev_re ? gpio_val : $urandom;
      prev_re = gpio_re;
      if (gpio_we) begin r_we_n++; r_we_data = gpio_wdata; end
      if (gpio_re) r_re_n++;
      if (gpio_we && gpio_re) r_both++;
      if (drop && n == 2) begin psel = 1'b0; penable = 1'b0; end
      if (pready) begin
        r_lat = n; r_rdata = prdata; r_err = pslverr;
        break;
      end
      if (n >= 8) begin
        $display("[TB] FAIL timeout: got no pready after %0d cycles, expected pready", n);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    r_pready_after = pready;
  endtask

  // Compute expectations from the register map rules, run the transfer, compare, then update the model.
  task automatic doTransfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input bit drop, input logic [31:0] gval);
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    bit          chk_rdata;
    int          exp_we;
    int          exp_re;
    gpio_val  = gval;
    exp_lat   = 2;
    exp_err   = 1'b0;
    exp_rdata = 32'h0;
    chk_rdata = !wr;
    exp_we    = 0;
    exp_re    = 0;
    case (addr)
      12'h000: begin
        if (wr) begin
          exp_lat = 3; exp_we = 1;
        end else begin
`ifdef GPIO_BRIDGE_SHADOW_EN
          exp_rdata = m_last_wr;
`else
          exp_lat = 4; exp_re = 1; exp_rdata = gval;
`endif
        end
      end
      12'h004: begin
        if (wr) exp_err = 1'b1;
        else exp_rdata = {m_err, m_wr};
      end
      12'h008: begin
        if (!wr) exp_rdata = m_scratch;
      end
      default: exp_err = 1'b1;
    endcase
    if (exp_err) begin chk_rdata = 1'b1; exp_rdata = 32'h0; end

    applyStimulus(wr, addr, wdata, drop);

    checkOutput("latency", r_lat, exp_lat);
    checkOutput("pslverr", {31'h0, r_err}, {31'h0, exp_err});
    if (chk_rdata) checkOutput("prdata", r_rdata, exp_rdata);
    checkOutput("we_cycles", r_we_n, exp_we);
    checkOutput("re_cycles", r_re_n, exp_re);
    checkOutput("we_re_overlap", r_both, 0);
    if (exp_we == 1) checkOutput("gpio_wdata_at_we", r_we_data, wdata);
    checkOutput("pready_pulse", {31'h0, r_pready_after}, 32'h0);

    if (addr == 12'h000 && wr) begin m_last_wr = wdata; m_wr = m_wr + 16'd1; end
    if (addr == 12'h008 && wr) m_scratch = wdata;
    if (exp_err && m_err < ERR_MAX) m_err = m_err + 16'd1;

    checkOutput("gpio_wdata_hold", gpio_wdata, m_last_wr);
  endtask

  initial begin
    logic [11:0] addr_tab [6];
    logic [11:0] a;
    addr_tab[0] = 12'h000; addr_tab[1] = 12'h004; addr_tab[2] = 12'h008;
    addr_tab[3] = 12'h00C; addr_tab[4] = 12'h002; addr_tab[5] = 12'h000;

    // reset held for two cycles
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rst_prdata", prdata, 32'h0);
    checkOutput("rst_pready", {31'h0, pready}, 32'h0);
    checkOutput("rst_pslverr", {31'h0, pslverr}, 32'h0);
    checkOutput("rst_gpio_we", {31'h0, gpio_we}, 32'h0);
    checkOutput("rst_gpio_re", {31'h0, gpio_re}, 32'h0);
    checkOutput("rst_gpio_wdata", gpio_wdata, 32'h0);
    reset = 1'b1;

    doTransfer(1'b0, 12'h004, 32'h0, 1'b0, 32'h0);
    doTransfer(1'b1, 12'h000, 32'hA5A5A5A5, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h004, 32'h0, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h000, 32'h0, 1'b0, 32'hDEADBEEF);
    doTransfer(1'b1, 12'h008, 32'h12345678, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h008, 32'h0, 1'b0, 32'h0);
    doTransfer(1'b1, 12'h004, 32'hFFFFFFFF, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h00C, 32'h0, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h002, 32'h0, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h004, 32'h0, 1'b0, 32'h0);
    checkOutput("err_cnt_three", {16'h0, r_rdata[31:16]}, 32'd3);

    // drive the error counter into saturation
    for (int i = 0; i < 6; i++) doTransfer(1'b0, 12'hFF0, 32'h0, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h004, 32'h0, 1'b0, 32'h0);
    checkOutput("err_cnt_sat", {16'h0, r_rdata[31:16]}, {16'h0, ERR_MAX});

    // reset landing in the gpio_re cycle of a DATA read
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    checkOutput("rd_strobe_before_reset", {31'h0, gpio_re}, 32'h1);
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_mid_pready", {31'h0, pready}, 32'h0);
    checkOutput("reset_mid_gpio_re", {31'h0, gpio_re}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_mid_pready_after", {31'h0, pready}, 32'h0);
    m_wr = 16'h0; m_err = 16'h0; m_scratch = 32'h0; m_last_wr = 32'h0;
    doTransfer(1'b1, 12'h000, 32'h0BADF00D, 1'b0, 32'h0);
    doTransfer(1'b0, 12'h004, 32'h0, 1'b0, 32'h0);

    // random traffic, including occasional early psel/penable drops
    for (int i = 0; i < 80; i++) begin
      a = addr_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 9) == 0) a = 12'($urandom);
      doTransfer(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 7) == 0), $urandom);
    end
    doTransfer(1'b0, 12'h004, 32'h0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
